lfsr8_checker: RTL and testbench

//  Receive-side PRBS checker for the 8-bit LFSR bitstream the HDSISO8 chip generates.
//  - Self-synchronises on the serial stream coming back from the SISO output.
//  - Predicts each next bit, then flags and counts mismatches.
//  - Declares loss of lock on an error burst; used for on-board loopback BER tests.

---
 rtl/hdsiso8_pkg.sv | 12 +
 rtl/sat_counter.sv | 23 ++
 rtl/lfsr8_checker.sv | 128 ++++++++++++
 tb/tb_lfsr8_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hdsiso8_pkg.sv
// Constants and types shared by the HDSISO8 PRBS generator and its receive-side checker.
package hdsiso8_pkg;

  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam int         CNT_W_DEFAULT = 16;

  typedef enum logic {
    HUNT  = 1'b0,
    CHECK = 1'b1
  } chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  // Clear has priority over an increment arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr8_checker.sv
// Self-synchronising PRBS checker for the HDSISO8 8-bit LFSR loopback stream:
// hunts for 8 seed bits, then flywheels the LFSR and counts bit mismatches.
module lfsr8_checker
  import hdsiso8_pkg::*;
#(
  parameter logic [7:0] TAPS      = LFSR_TAPS,
  parameter int         ERR_LIMIT = 4,
  parameter int         WINDOW    = 64,
  parameter int         CNT_W     = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             D_IN,
  input  logic             CLR,
  output logic             LOCK,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] BIT_CNT,
  output logic             STUCK
);

  localparam int WIN_W  = $clog2(WINDOW);
  localparam int WERR_W = $clog2(WINDOW + 1);
  localparam logic [WERR_W-1:0] LIMIT = WERR_W'(ERR_LIMIT);

  chk_state_t        state_q, state_d;
  logic [7:0]        hist_q, hist_d;
  logic [2:0]        fill_q, fill_d;
  logic [WIN_W-1:0]  win_q, win_d, win_inc;
  logic [WERR_W-1:0] werr_q, werr_d, werr_sum;
  logic              err_q, err_d;
  logic              stuck_q, stuck_d;
  logic              pred, mis, bit_inc, err_inc;

  assign pred    = ^(hist_q & TAPS);
  assign mis     = D_IN ^ pred;
  assign win_inc = win_q + 1'b1;
  // The bit that wraps the window counter is the first bit of the new window.
  assign werr_sum = ((win_inc == '0) ? '0 : werr_q) + WERR_W'(mis);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    win_d   = win_q;
    werr_d  = werr_q;
    err_d   = 1'b0;
    stuck_d = stuck_q;
    bit_inc = 1'b0;
    err_inc = 1'b0;
    if (EN) begin
      case (state_q)
        HUNT: begin
          hist_d = {hist_q[6:0], D_IN};
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd7) begin
            fill_d = 3'd0;
            if ({hist_q[6:0], D_IN} == 8'h00) begin
              stuck_d = 1'b1;
            end else begin
              stuck_d = 1'b0;
              state_d = CHECK;
              win_d   = '0;
              werr_d  = '0;
            end
          end
        end
        CHECK: begin
          // Feed back the prediction, not the received bit, so line errors stay isolated.
          hist_d  = {hist_q[6:0], pred};
          bit_inc = 1'b1;
          err_inc = mis;
          err_d   = mis;
          win_d   = win_inc;
          werr_d  = werr_sum;
          if (werr_sum >= LIMIT) begin
            state_d = HUNT;
            fill_d  = 3'd0;
            hist_d  = 8'h00;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= HUNT;
      hist_q  <= 8'h00;
      fill_q  <= 3'd0;
      win_q   <= '0;
      werr_q  <= '0;
      err_q   <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      err_q   <= err_d;
      stuck_q <= stuck_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_bit_cnt (
    .clk   (CLK),
    .rst_n (RESET),
    .inc   (bit_inc),
    .clr   (CLR),
    .q     (BIT_CNT)
  );

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (CLK),
    .rst_n (RESET),
    .inc   (err_inc),
    .clr   (CLR),
    .q     (ERR_CNT)
  );

  assign LOCK  = (state_q == CHECK);
  assign ERR   = err_q;
  assign STUCK = stuck_q;

endmodule

// File: tb/tb_lfsr8_checker.sv
// Randomised bench for lfsr8_checker: a default instance and a 4-bit-counter instance
// share stimulus and are compared every cycle against a recurrence-based reference model.
module tb_lfsr8_checker;

  localparam logic [7:0] REF_TAPS = 8'hB8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic d_in = 1'b0;
  logic clr = 1'b0;

  logic        lock0, err0, stuck0;
  logic [15:0] ecnt0, bcnt0;
  logic        lock1, err1, stuck1;
  logic [3:0]  ecnt1, bcnt1;

  int checks = 0;
  int failures = 0;

  // Per-instance reference parameters and model state.
  int pLimit [2] = '{4, 64};
  int pMax   [2] = '{65535, 15};
  bit mSeq   [2][256];
  int mN     [2];
  bit mLock  [2];
  bit mStuck [2];
  bit mErr   [2];
  int mBits  [2];
  int mErrs  [2];
  int mK     [2];
  int mWid   [2];
  int mWerr  [2];

  bit gSeq [256];
  int gN;

  always #5 clk = ~clk;

  lfsr8_checker dut (
    .CLK(clk), .RESET(reset_n), .EN(en), .D_IN(d_in), .CLR(clr),
    .LOCK(lock0), .ERR(err0), .ERR_CNT(ecnt0), .BIT_CNT(bcnt0), .STUCK(stuck0)
  );

  lfsr8_checker #(.ERR_LIMIT(64), .WINDOW(64), .CNT_W(4)) dut_sat (
    .CLK(clk), .RESET(reset_n), .EN(en), .D_IN(d_in), .CLR(clr),
    .LOCK(lock1), .ERR(err1), .ERR_CNT(ecnt1), .BIT_CNT(bcnt1), .STUCK(stuck1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Next PRBS bit from b[n] = XOR of b[n-k] for every tap k.
  task automatic genBit(output bit b);
    b = 1'b0;
    for (int k = 1; k <= 8; k++) if (REF_TAPS[k-1]) b ^= gSeq[(gN - k) % 256];
    gSeq[gN % 256] = b;
    gN++;
  endtask

  task automatic modelStep(input int i, input bit rst, input bit e, input bit d, input bit c);
    bit p, mis, allZero;
    if (!rst) begin
      mN[i] = 0; mLock[i] = 0; mStuck[i] = 0; mErr[i] = 0; mBits[i] = 0; mErrs[i] = 0;
      return;
    end
    mErr[i] = 0;
    if (e) begin
      if (!mLock[i]) begin
        mSeq[i][mN[i] % 256] = d;
        mN[i]++;
        if (mN[i] == 8) begin
          allZero = 1'b1;
          for (int j = 0; j < 8; j++) if (mSeq[i][j]) allZero = 1'b0;
          if (allZero) begin
            mStuck[i] = 1; mN[i] = 0;
          end else begin
            mStuck[i] = 0; mLock[i] = 1; mK[i] = 0; mWid[i] = 0; mWerr[i] = 0;
          end
        end
      end else begin
        p = 1'b0;
        for (int k = 1; k <= 8; k++) if (REF_TAPS[k-1]) p ^= mSeq[i][(mN[i] - k) % 256];
        mis = d ^ p;
        mSeq[i][mN[i] % 256] = p;
        mN[i]++;
        mK[i]++;
        if (mK[i] / 64 != mWid[i]) begin
          mWid[i] = mK[i] / 64;
          mWerr[i] = 0;
        end
        mWerr[i] += int'(mis);
        if (!c) begin
          if (mBits[i] < pMax[i]) mBits[i]++;
          if (mis && mErrs[i] < pMax[i]) mErrs[i]++;
        end
        mErr[i] = mis;
        if (mWerr[i] >= pLimit[i]) begin
          mLock[i] = 0; mN[i] = 0;
        end
      end
    end
    if (c) begin
      mBits[i] = 0; mErrs[i] = 0;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit e, input bit d, input bit c);
    reset_n = rst; en = e; d_in = d; clr = c;
    @(posedge clk);
    modelStep(0, rst, e, d, c);
    modelStep(1, rst, e, d, c);
    #1;
    checkOutput("lock0",  32'(lock0),  32'(mLock[0]));
    checkOutput("err0",   32'(err0),   32'(mErr[0]));
    checkOutput("stuck0", 32'(stuck0), 32'(mStuck[0]));
    checkOutput("bcnt0",  32'(bcnt0),  mBits[0]);
    checkOutput("ecnt0",  32'(ecnt0),  mErrs[0]);
    checkOutput("lock1",  32'(lock1),  32'(mLock[1]));
    checkOutput("err1",   32'(err1),   32'(mErr[1]));
    checkOutput("stuck1", 32'(stuck1), 32'(mStuck[1]));
    checkOutput("bcnt1",  32'(bcnt1),  mBits[1]);
    checkOutput("ecnt1",  32'(ecnt1),  mErrs[1]);
  endtask

  task automatic sendGen(input bit flip, input bit c);
    bit b;
    genBit(b);
    applyStimulus(1'b1, 1'b1, b ^ flip, c);
  endtask

  initial begin
    logic [7:0] seed;
    seed = 8'($urandom_range(1, 255));
    for (int j = 0; j < 8; j++) gSeq[j] = seed[j];
    gN = 8;

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_lock", 32'(lock0), 0);
    checkOutput("reset_bcnt", 32'(bcnt0), 0);

    // Clean stream from reset: 8 hunt bits then 292 checked.
    for (int i = 0; i < 300; i++) sendGen(1'b0, 1'b0);
    checkOutput("s1_bitcnt", 32'(bcnt0), 292);
    checkOutput("s1_errcnt", 32'(ecnt0), 0);

    // Single inverted bit.
    for (int i = 1; i <= 150; i++) sendGen(i == 100, 1'b0);
    checkOutput("s2_errcnt", 32'(ecnt0), 1);
    checkOutput("s2_lock", 32'(lock0), 1);

    // Error burst inside one window drops lock, then relock.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    for (int g = 0; g < 64 && (mK[0] % 64) != 0; g++) sendGen(1'b0, 1'b0);
    for (int i = 0; i <= 6; i++) sendGen(i % 2 == 0, 1'b0);
    checkOutput("s3_lockdrop", 32'(lock0), 0);
    checkOutput("s3_errcnt", 32'(ecnt0), 4);
    for (int i = 0; i < 8; i++) sendGen(1'b0, 1'b0);
    checkOutput("s3_relock", 32'(lock0), 1);
    for (int i = 1; i <= 70; i++) sendGen(i == 62 || i == 63 || i == 64, 1'b0);
    checkOutput("s3_split_lock", 32'(lock0), 1);

    // Stuck-low line.
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("s4_stuck", 32'(stuck0), 1);
    checkOutput("s4_lock", 32'(lock0), 0);
    checkOutput("s4_bcnt", 32'(bcnt0), 0);
    for (int i = 0; i < 30; i++) sendGen(1'b0, 1'b0);
    checkOutput("s4_relock", 32'(lock0), 1);
    checkOutput("s4_unstuck", 32'(stuck0), 0);

    // EN strobed one cycle in three.
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 900; c++) begin
      if (c % 3 == 0) sendGen(1'b0, 1'b0);
      else applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    checkOutput("s5_bcnt", 32'(bcnt0), 292);
    checkOutput("s5_ecnt", 32'(ecnt0), 0);

    // CLR together with an error, then reset while locked.
    sendGen(1'b1, 1'b1);
    checkOutput("s5_clr_err", 32'(err0), 1);
    checkOutput("s5_clr_ecnt", 32'(ecnt0), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("s5_rst_lock", 32'(lock0), 0);
    checkOutput("s5_rst_err", 32'(err0), 0);

    // Error counter saturation on the 4-bit instance.
    for (int i = 0; i < 20; i++) sendGen(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) sendGen(1'b1, 1'b0);
    checkOutput("s6_sat_ecnt", 32'(ecnt1), 15);
    checkOutput("s6_sat_lock", 32'(lock1), 1);

    // Random mix of strobes, line errors, clears and resets.
    for (int c = 0; c < 1500; c++) begin
      bit b, rst, e, flip, cl, d;
      rst  = $urandom_range(0, 999) >= 3;
      e    = $urandom_range(0, 9) < 8;
      flip = $urandom_range(0, 99) < 4;
      cl   = $urandom_range(0, 99) < 2;
      if (e) begin
        genBit(b);
        d = b ^ flip;
      end else begin
        d = 1'($urandom_range(0, 1));
      end
      applyStimulus(rst, e, d, cl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
